// File: rtl/demux2x64_buf_pkg.sv
// Shared definitions for the demux2x64_buf block.
//   WIDTH        : default data width of one lane word
//   NLANES       : number of output lanes fed by the demux
//   lane_state_e : occupancy state of one 2-entry lane buffer
package demux2x64_buf_pkg;

  localparam int WIDTH  = 64;
  localparam int NLANES = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_e;

endpackage : demux2x64_buf_pkg

// File: rtl/demux_lane.sv
// One 2-entry FIFO lane of the demux buffer.
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write din at the tail (caller guarantees the lane is not full)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, registered
//   valid      : lane holds at least one entry
//   full       : lane holds two entries
module demux_lane
  import demux2x64_buf_pkg::*;
#(
  parameter int WIDTH = demux2x64_buf_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = din;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_d = FULL;
            tail_d  = din;
          end
          2'b01: state_d = EMPTY;
          // Push and pop together: the single entry is replaced, occupancy unchanged.
          2'b11: head_d = din;
          default: ;
        endcase
      end
      FULL: begin
        // Push cannot occur here: the top level holds in_ready low for a full lane.
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      // NOTE: data registers are reset too so head is never X after reset, not just "invalid".
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head  = head_q;
  assign valid = (state_q != EMPTY);
  assign full  = (state_q == FULL);

endmodule : demux_lane

// File: rtl/demux2x64_buf.sv
// 1-to-2 demultiplexer with a 2-entry buffer per output lane.
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : producer handshake; in_ready = selected lane not full
//   in_sel, in_data     : destination lane and word
//   out_valid/out_ready : per-lane consumer handshake
//   out_data[lane]      : per-lane head word
module demux2x64_buf
  import demux2x64_buf_pkg::*;
#(
  parameter int WIDTH = demux2x64_buf_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sel,
  input  logic [WIDTH-1:0]              in_data,
  output logic [NLANES-1:0]             out_valid,
  input  logic [NLANES-1:0]             out_ready,
  output logic [NLANES-1:0][WIDTH-1:0]  out_data
);

  // The lane buffer is hard-wired for two entries.
  if (DEPTH != 2) begin : g_bad_depth
    $error("demux2x64_buf: only DEPTH=2 is supported");
  end

  logic [NLANES-1:0] lane_full;
  logic [NLANES-1:0] lane_push;
  logic [NLANES-1:0] lane_pop;

  // Depends only on in_sel and lane occupancy, never on in_valid or out_ready.
  assign in_ready = ~lane_full[in_sel];
  assign lane_pop = out_valid & out_ready;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    assign lane_push[g] = in_valid && in_ready && (in_sel == 1'(g));

    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (lane_push[g]),
      .pop   (lane_pop[g]),
      .din   (in_data),
      .head  (out_data[g]),
      .valid (out_valid[g]),
      .full  (lane_full[g])
    );
  end

endmodule : demux2x64_buf
